// File: rtl/ltpi_pkg.sv
// Shared LTPI definitions: frame constants, NL GPIO chunk type and the
// NL GPIO transmit FSM state type.
package ltpi_pkg;

    localparam int unsigned LTPI_NL_GPIO_PER_FRM = 16;
    localparam int unsigned LTPI_GPIO_IDX_W      = 8;
    localparam int unsigned LTPI_NL_GPIO_MAX     = 1024;

    typedef struct packed {
        logic [LTPI_GPIO_IDX_W-1:0]      index;
        logic [LTPI_NL_GPIO_PER_FRM-1:0] data;
    } nl_gpio_chunk_t;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND
    } nl_gpio_tx_state_t;

    // Number of frame-sized chunks needed to carry gpio_num bits.
    function automatic int unsigned nl_gpio_num_chunks(int unsigned gpio_num,
                                                       int unsigned per_frm);
        return (gpio_num + per_frm - 1) / per_frm;
    endfunction

endpackage

// File: rtl/ltpi_gpio_sync.sv
// Per-bit 2-flop synchroniser for asynchronous board GPIO inputs.
// Both stages reset to 0.
module ltpi_gpio_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_raw,
    output logic [WIDTH-1:0] gpio_sync
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture chain; second stage is the clean output.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= '0;
            gpio_sync <= '0;
        end else begin
            meta      <= gpio_raw;
            gpio_sync <= meta;
        end
    end

endmodule

// File: rtl/ltpi_nl_gpio_tx.sv
// Normal-latency GPIO transmit stage. Takes one coherent snapshot of the NL
// GPIOs per sweep and hands it to the frame builder as 16-bit chunks with an
// 8-bit index, round-robin, using a valid/ready handshake.
// Optional build macro: LTPI_NL_GPIO_SYNC_EN (adds a 2-flop input synchroniser).
module ltpi_nl_gpio_tx
    import ltpi_pkg::*;
#(
    parameter int unsigned NL_GPIO_NUM     = 64,
    parameter int unsigned NL_GPIO_PER_FRM = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   link_operational,
    input  logic [NL_GPIO_NUM-1:0] nl_gpio_in,
    output logic [15:0]            nl_gpio_data,
    output logic [7:0]             nl_gpio_index,
    output logic                   nl_gpio_valid,
    input  logic                   nl_gpio_ready,
    output logic                   nl_gpio_sweep
);

    localparam int unsigned NUM_CHUNKS = nl_gpio_num_chunks(NL_GPIO_NUM, NL_GPIO_PER_FRM);
    localparam int unsigned PAD_W      = NUM_CHUNKS * NL_GPIO_PER_FRM;
    localparam int unsigned SEL_W      = (PAD_W > 1) ? $clog2(PAD_W) : 1;
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_CHUNKS - 1);

    logic [NL_GPIO_NUM-1:0] gpio_src;
    logic [PAD_W-1:0]       snap_in;
    logic [PAD_W-1:0]       snapshot;
    logic [SEL_W-1:0]       bit_sel;

    nl_gpio_tx_state_t state_q, state_d;
    logic [7:0]        index_q, index_d;
    logic              snap_load;
    logic              sweep_c;
    nl_gpio_chunk_t    chunk;

`ifdef LTPI_NL_GPIO_SYNC_EN
    ltpi_gpio_sync #(
        .WIDTH (NL_GPIO_NUM)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .gpio_raw  (nl_gpio_in),
        .gpio_sync (gpio_src)
    );
`else
    assign gpio_src = nl_gpio_in;
`endif

    // Zero-pad the input vector up to a whole number of chunks.
    always_comb begin
        snap_in                   = '0;
        snap_in[NL_GPIO_NUM-1:0]  = gpio_src;
    end

    // State, chunk index and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            snapshot <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (snap_load) begin
                snapshot <= snap_in;
            end
        end
    end

    // Next-state logic; a dropped link overrides every state transition.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        snap_load = 1'b0;
        sweep_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                index_d = '0;
                if (link_operational) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_load = 1'b1;
                index_d   = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (nl_gpio_ready) begin
                    if (index_q == LAST_IDX) begin
                        sweep_c = 1'b1;
                        index_d = '0;
                        state_d = SNAP;
                    end else begin
                        index_d = index_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
        if (!link_operational) begin
            state_d   = IDLE;
            index_d   = '0;
            snap_load = 1'b0;
            sweep_c   = 1'b0;
        end
    end

    // Chunk slice is a part-select of the snapshot at index*16.
    assign bit_sel    = SEL_W'({index_q, 4'b0000});
    assign chunk.index = index_q;
    assign chunk.data  = snapshot[bit_sel +: NL_GPIO_PER_FRM];

    assign nl_gpio_data  = chunk.data;
    assign nl_gpio_index = chunk.index;
    assign nl_gpio_valid = (state_q == SEND);
    assign nl_gpio_sweep = sweep_c && !reset;

endmodule

// File: tb/tb_ltpi_nl_gpio_tx.sv
// Bench for ltpi_nl_gpio_tx: three instances (64, 20 and 1 GPIOs) driven with
// directed and random stimulus, checked against a sweep-level reference model.
module tb_ltpi_nl_gpio_tx;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        link = 1'b0;
    logic [63:0] in64 = '0;
    logic [19:0] in20 = '0;
    logic [0:0]  in1  = '0;

    logic        rdy [NI];
    logic        vld [NI];
    logic [15:0] dat [NI];
    logic [7:0]  idx [NI];
    logic        swp [NI];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    ltpi_nl_gpio_tx #(.NL_GPIO_NUM(64)) u_dut64 (
        .clk(clk), .reset(reset), .link_operational(link), .nl_gpio_in(in64),
        .nl_gpio_data(dat[0]), .nl_gpio_index(idx[0]), .nl_gpio_valid(vld[0]),
        .nl_gpio_ready(rdy[0]), .nl_gpio_sweep(swp[0]));

    ltpi_nl_gpio_tx #(.NL_GPIO_NUM(20)) u_dut20 (
        .clk(clk), .reset(reset), .link_operational(link), .nl_gpio_in(in20),
        .nl_gpio_data(dat[1]), .nl_gpio_index(idx[1]), .nl_gpio_valid(vld[1]),
        .nl_gpio_ready(rdy[1]), .nl_gpio_sweep(swp[1]));

    ltpi_nl_gpio_tx #(.NL_GPIO_NUM(1)) u_dut1 (
        .clk(clk), .reset(reset), .link_operational(link), .nl_gpio_in(in1),
        .nl_gpio_data(dat[2]), .nl_gpio_index(idx[2]), .nl_gpio_valid(vld[2]),
        .nl_gpio_ready(rdy[2]), .nl_gpio_sweep(swp[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned gpio_num(input int i);
        case (i)
            0:       return 64;
            1:       return 20;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] raw_in(input int i);
        case (i)
            0:       return in64;
            1:       return {44'b0, in20};
            default: return {63'b0, in1};
        endcase
    endfunction

    // Reference model: input history (h0 = this cycle, h2 = two cycles ago),
    // the snapshot of the sweep in progress and the position within it.
    logic [63:0] h0 [NI], h1 [NI], h2 [NI], m_snap [NI];
    bit          m_busy [NI], m_pend [NI];
    int unsigned m_pos [NI];
    bit          prev_rst = 1'b1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            h0[i] = '0; h1[i] = '0; h2[i] = '0; m_snap[i] = '0;
            m_busy[i] = 0; m_pend[i] = 0; m_pos[i] = 0; rdy[i] = 1'b0;
        end
    end

    task automatic model_step(input int i);
        int unsigned nch;
        logic [63:0] shifted;
        logic [63:0] captured;
        bit          acc;
        nch = (gpio_num(i) + 15) / 16;
        h2[i] = h1[i];
        h1[i] = h0[i];
        h0[i] = raw_in(i);
        if (reset) begin
            m_busy[i] = 0; m_pend[i] = 0; m_pos[i] = 0;
            h0[i] = '0; h1[i] = '0;
            return;
        end
        if (prev_rst) begin
            chk($sformatf("dut%0d.reset_data", i), 64'(dat[i]), 64'h0);
            chk($sformatf("dut%0d.reset_sweep", i), 64'(swp[i]), 64'h0);
        end
        chk($sformatf("dut%0d.valid", i), 64'(vld[i]), 64'(m_busy[i]));
        if (m_busy[i]) begin
            shifted = m_snap[i] >> (16 * m_pos[i]);
            chk($sformatf("dut%0d.index", i), 64'(idx[i]), 64'(m_pos[i]));
            chk($sformatf("dut%0d.data", i), 64'(dat[i]), {48'b0, shifted[15:0]});
        end else begin
            chk($sformatf("dut%0d.idle_index", i), 64'(idx[i]), 64'h0);
        end
        acc = m_busy[i] && rdy[i];
        chk($sformatf("dut%0d.sweep", i), 64'(swp[i]),
            64'(acc && link && (m_pos[i] == nch - 1)));
`ifdef LTPI_NL_GPIO_SYNC_EN
        captured = h2[i];
`else
        captured = h0[i];
`endif
        if (!link) begin
            m_busy[i] = 0; m_pend[i] = 0; m_pos[i] = 0;
        end else if (m_pend[i]) begin
            m_snap[i] = captured;
            m_busy[i] = 1; m_pend[i] = 0; m_pos[i] = 0;
        end else if (m_busy[i]) begin
            if (acc) begin
                if (m_pos[i] == nch - 1) begin
                    m_busy[i] = 0; m_pend[i] = 1; m_pos[i] = 0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end else begin
            m_pend[i] = 1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
        prev_rst = reset;
    end

    task automatic set_ready(input logic r);
        for (int i = 0; i < NI; i++) rdy[i] = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx64(input logic [7:0] target, input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (vld[0] && idx[0] == target) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(tag, 64'(ok), 64'h1);
    endtask

    logic [15:0] tbl64 [4];
    logic [15:0] tbl20 [2];

    initial begin
        tbl64[0] = 16'hCDEF; tbl64[1] = 16'h89AB; tbl64[2] = 16'h4567; tbl64[3] = 16'h0123;
        tbl20[0] = 16'hBCDE; tbl20[1] = 16'h000A;

        reset = 1'b1; link = 1'b0; set_ready(1'b0);
        repeat (3) step();

        // Basic round-robin with constant inputs.
        reset = 1'b0; link = 1'b1; set_ready(1'b1);
        in64 = 64'h0123_4567_89AB_CDEF; in20 = 20'hABCDE; in1 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (vld[0] && rdy[0]) chk("t1_chunk64", 64'(dat[0]), 64'(tbl64[idx[0][1:0]]));
            if (vld[1] && rdy[1]) chk("t4_chunk20", 64'(dat[1]), 64'(tbl20[idx[1][0]]));
            step();
        end

        // Backpressure while chunk 1 is presented.
        wait_idx64(8'd1, "bp_reach_idx1");
        set_ready(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(vld[0]), 64'h1);
            chk("bp_hold_index", 64'(idx[0]), 64'h1);
            chk("bp_hold_data", 64'(dat[0]), 64'h89AB);
            step();
        end
        set_ready(1'b1);
        step();

        // Mid-sweep change after chunk 1 accepted.
        wait_idx64(8'd2, "mid_reach_idx2");
        in64 = 64'hFEDC_BA98_7654_3210;
        repeat (12) step();

        // Link drop with chunk 2 valid.
        wait_idx64(8'd2, "drop_reach_idx2");
        link = 1'b0;
        in64 = 64'h1111_2222_3333_4444;
        step();
        @(negedge clk);
        chk("drop_valid", 64'(vld[0]), 64'h0);
        step();
        link = 1'b1;
        repeat (10) step();

        // Reset mid-sweep.
        wait_idx64(8'd2, "rst_reach_idx2");
        reset = 1'b1;
        step();
        reset = 1'b0;
        in64 = 64'h5555_6666_7777_8888;
        repeat (10) step();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) link = ~link;
            for (int i = 0; i < NI; i++) rdy[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) in64 = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) in20 = 20'($urandom);
            if ($urandom_range(0, 2) == 0) in1  = 1'($urandom);
            step();
        end
        reset = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
